// File: rtl/axi2apb_write_sequencer.sv
// Write-side engine of the AXI2APB bridge: takes one AXI write burst from the
// front end, drains its data from the write FIFO beat by beat as APB writes,
// then has the front end return the merged B response.
module axi2apb_write_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [1:0]            rd_cmd,
  input  logic [1:0]            rd_info,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [3:0]            len_in,
  input  logic [2:0]            size_in,
  input  logic [1:0]            burst_in,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_read,
  output logic [1:0]            wr_resp,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH/8));

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_ACCESS = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [1:0] CMD_NONE     = 2'd0;
  localparam logic [1:0] CMD_GET_AD   = 2'd1;
  localparam logic [1:0] CMD_GET_RESP = 2'd2;
  localparam logic [1:0] INFO_IDLE    = 2'd0;
  localparam logic [1:0] INFO_SWITCH  = 2'd2;

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [1:0]            wr_resp_q, wr_resp_d;

  logic [ADDR_WIDTH-1:0] incr, wrap_mask, next_addr;
  logic                  wrap_ok;

  // Next beat address from the current one (paddr_q always holds the last issued beat)
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    wrap_ok   = (burst_q == 2'd2) &&
                (len_q == 4'd1 || len_q == 4'd3 || len_q == 4'd7 || len_q == 4'd15);
    if (burst_q == 2'd0)
      next_addr = paddr_q;
    else if (wrap_ok)
      next_addr = (paddr_q & ~wrap_mask) | ((paddr_q + incr) & wrap_mask);
    else
      next_addr = paddr_q + incr;  // INCR, reserved burst and non-legal WRAP lengths
  end

  // Sequencer: burst request, per-beat FIFO pop and APB transfer, response hand-off
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    wr_resp_d = wr_resp_q;
    fifo_read = 1'b0;
    rd_cmd    = CMD_NONE;
    case (state_q)
      S_IDLE: if (en && rd_info == INFO_IDLE) begin
        state_d   = S_REQ;
        cnt_d     = 4'd0;
        err_d     = 1'b0;
        wr_resp_d = 2'b00;
      end
      S_REQ: begin
        rd_cmd  = CMD_GET_AD;
        state_d = S_FETCH;
      end
      S_FETCH: if (!fifo_empty) begin
        fifo_read = 1'b1;
        pwdata_d  = fifo_rdata;
        state_d   = S_SETUP;
        if (cnt_q == 4'd0) begin
          // first beat: burst attributes are captured here and checked once
          paddr_d = addr_in;
          len_d   = len_in;
          size_d  = size_in;
          burst_d = burst_in;
          if (size_in > SIZE_MAX || burst_in == 2'd3) err_d = 1'b1;
        end else begin
          paddr_d = next_addr;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: if (pready) begin
        err_d = err_q | pslverr;
        if (cnt_q == len_q) begin
          state_d   = S_RESP;
          wr_resp_d = {err_d, 1'b0};
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_RESP: if (rd_info == INFO_SWITCH) begin
        rd_cmd  = CMD_GET_RESP;
        state_d = S_DONE;
      end
      S_DONE: if (rd_info == INFO_IDLE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
  end

  // State and registered outputs; async reset abandons any in-flight transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      len_q     <= 4'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      wr_resp_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      wr_resp_q <= wr_resp_d;
    end
  end

  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign wr_resp = wr_resp_q;
  assign pwrite  = 1'b1;

endmodule
